modular_addsub_pipe: RTL and testbench

Parametrised, pipelined modular adder/subtractor for the NTT datapath. It computes (a ± b) mod q, where q is selected at runtime from a compile-time modulus table. It accepts one operation per cycle through a valid/ready handshake, so it can sit directly between the butterfly multiplier output and the coefficient write-back path. It generalises the single-width, single-operation modular adder to configurable width and table depth, adds stall-capable flow control, and adds an optional subtract mode.

---
 rtl/mod_arith_pkg.sv | 23 ++
 rtl/modular_addsub_pipe_if.sv | 31 +++
 rtl/mod_correct.sv | 27 ++
 rtl/modular_addsub_pipe.sv | 115 +++++++++++
 tb/tb_modular_addsub_pipe.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mod_arith_pkg.sv
// Shared modular-arithmetic constants for the NTT datapath: default widths and the
// runtime-selectable modulus table.
package mod_arith_pkg;

    localparam int unsigned DEF_WIDTH   = 30;
    localparam int unsigned DEF_NUM_MOD = 16;
    localparam int unsigned DEF_IDX_W   = $clog2(DEF_NUM_MOD);

    typedef logic [DEF_WIDTH-1:0] modulus_t;

    // NTT-friendly primes of the form k*2^m + 1, all below 2^30.
    localparam modulus_t MOD_TABLE [DEF_NUM_MOD] = '{
        30'd998244353,  30'd754974721,  30'd167772161,  30'd469762049,
        30'd1004535809, 30'd985661441,  30'd943718401,  30'd1045430273,
        30'd1051721729, 30'd1053818881, 30'd1012924417, 30'd962592769,
        30'd950009857,  30'd924844033,  30'd595591169,  30'd645922817
    };

    function automatic modulus_t mod_lookup(input logic [DEF_IDX_W-1:0] idx);
        return MOD_TABLE[idx];
    endfunction

endpackage

// File: rtl/modular_addsub_pipe_if.sv
// Operand/result handshake and modulus-select bundle for modular_addsub_pipe.
interface modular_addsub_pipe_if
    import mod_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned IDX_W = DEF_IDX_W
) ();

    logic             mod_load;
    logic [IDX_W-1:0] mod_index;
    logic [IDX_W-1:0] cur_index;
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;

    modport master (
        output mod_load, mod_index, in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, c, cur_index
    );

    modport slave (
        input  mod_load, mod_index, in_valid, op, a, b, out_ready,
        output in_ready, out_valid, c, cur_index
    );

endinterface

// File: rtl/mod_correct.sv
// Single conditional correction bringing a raw sum/difference back into [0, q).
// The subtract (borrow) branch exists only when MODADD_SUB_EN is defined.
module mod_correct #(
    parameter int unsigned WIDTH = 30
) (
    input  logic [WIDTH:0]   s,
    input  logic [WIDTH-1:0] q,
`ifdef MODADD_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] c
);

    always_comb begin
        c = s[WIDTH-1:0];
        if (s >= {1'b0, q}) begin
            c = WIDTH'(s - {1'b0, q});
        end
`ifdef MODADD_SUB_EN
        // For subtraction s[WIDTH] is the borrow, so wrap back up by q.
        if (sub) begin
            c = s[WIDTH] ? s[WIDTH-1:0] + q : s[WIDTH-1:0];
        end
`endif
    end

endmodule

// File: rtl/modular_addsub_pipe.sv
// Two-stage pipelined (a +/- b) mod q with valid/ready flow control and a runtime modulus
// index. Subtraction is enabled by defining MODADD_SUB_EN; otherwise every op is an add.
module modular_addsub_pipe
    import mod_arith_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned NUM_MOD = DEF_NUM_MOD,
    parameter int unsigned IDX_W   = $clog2(NUM_MOD)
) (
    input logic                  clk,
    input logic                  rst_n,
    modular_addsub_pipe_if.slave bus
);

    logic [IDX_W-1:0] cur_index_q;
    logic [WIDTH-1:0] q_sel;

    logic             en1;
    logic             en2;
    logic             accept;

    logic             s1_valid_q;
    logic [WIDTH:0]   s1_sum_d;
    logic [WIDTH:0]   s1_sum_q;
    logic [WIDTH-1:0] s1_mod_q;

    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_c_d;
    logic [WIDTH-1:0] s2_c_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_index_q <= '0;
        end else if (bus.mod_load) begin
            cur_index_q <= bus.mod_index;
        end
    end

    // q is sampled at accept and carried with the op, so later mod_loads never touch it.
    assign q_sel = WIDTH'(mod_lookup(DEF_IDX_W'(cur_index_q)));

    assign en2          = !s2_valid_q || bus.out_ready;
    assign en1          = !s1_valid_q || en2;
    assign accept       = bus.in_valid && en1;
    assign bus.in_ready = en1;

`ifdef MODADD_SUB_EN
    logic s1_op_q;

    always_comb begin
        s1_sum_d = {1'b0, bus.a} + {1'b0, bus.b};
        if (bus.op) begin
            s1_sum_d = {1'b0, bus.a} - {1'b0, bus.b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_op_q <= 1'b0;
        end else if (accept) begin
            s1_op_q <= bus.op;
        end
    end
`else
    logic unused_op;

    assign unused_op = bus.op;

    always_comb begin
        s1_sum_d = {1'b0, bus.a} + {1'b0, bus.b};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_mod_q   <= '0;
        end else if (en1) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sum_q <= s1_sum_d;
                s1_mod_q <= q_sel;
            end
        end
    end

    mod_correct #(
        .WIDTH (WIDTH)
    ) u_correct (
        .s   (s1_sum_q),
        .q   (s1_mod_q),
`ifdef MODADD_SUB_EN
        .sub (s1_op_q),
`endif
        .c   (s2_c_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_c_q     <= '0;
        end else if (en2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_c_q <= s2_c_d;
            end
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.c         = s2_c_q;
    assign bus.cur_index = cur_index_q;

endmodule

// File: tb/tb_modular_addsub_pipe.sv
// Directed, table-driven bench for modular_addsub_pipe; subtraction vectors are added
// when MODADD_SUB_EN is defined.
module tb_modular_addsub_pipe;
    import mod_arith_pkg::*;

    localparam int unsigned W  = DEF_WIDTH;
    localparam int unsigned IW = DEF_IDX_W;
    localparam int unsigned Q7 = MOD_TABLE[7];
    localparam int unsigned Q3 = MOD_TABLE[3];

    typedef logic [W-1:0] word_t;
    typedef struct {
        logic  op;
        word_t a;
        word_t b;
        word_t exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    modular_addsub_pipe_if #(.WIDTH(W), .IDX_W(IW)) bus ();

    modular_addsub_pipe #(
        .WIDTH   (W),
        .NUM_MOD (DEF_NUM_MOD),
        .IDX_W   (IW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    res_idx = 0;
    word_t exp_q[$];
    int    out_cycs[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int unsigned op, input int unsigned a,
                                input int unsigned b, input int unsigned e);
        vec_t v;
        v.op  = (op != 0);
        v.a   = word_t'(a);
        v.b   = word_t'(b);
        v.exp = word_t'(e);
        return v;
    endfunction

    // Scoreboard: every transfer on the output must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            out_cycs.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got c=%0d, required no result", bus.c);
            end else begin
                word_t e;
                e = exp_q.pop_front();
                check($sformatf("result_%0d", res_idx), 64'(bus.c), 64'(e));
                res_idx++;
            end
        end
    end

    task automatic send(input vec_t v);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.op       = v.op;
        bus.a        = v.a;
        bus.b        = v.b;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=0 for %0d cycles, required 1", guard);
        end else begin
            exp_q.push_back(v.exp);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_missing_results", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];

        vecs.push_back(mk(0, 10, 20, 30));
        vecs.push_back(mk(0, Q7 - 1, 1, 0));
        vecs.push_back(mk(0, 10, Q7 - 1, 9));
        vecs.push_back(mk(0, Q7 - 1, Q7 - 1, Q7 - 2));
`ifdef MODADD_SUB_EN
        vecs.push_back(mk(1, 20, 10, 10));
        vecs.push_back(mk(1, 10, 20, Q7 - 10));
        vecs.push_back(mk(1, 0, Q7 - 1, 1));
        vecs.push_back(mk(1, 5, 5, 0));
`endif

        bus.mod_load  = 1'b0;
        bus.mod_index = '0;
        bus.in_valid  = 1'b0;
        bus.op        = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_c", 64'(bus.c), 64'(0));
        check("rst_cur_index", 64'(bus.cur_index), 64'(0));
        rst_n = 1'b1;
        #1;
        check("in_ready_after_rst", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;

        bus.mod_load  = 1'b1;
        bus.mod_index = IW'(7);
        @(posedge clk);
        #1;
        bus.mod_load = 1'b0;
        check("cur_index_7", 64'(bus.cur_index), 64'(7));

        // Latency: inputs driven after edge N, result visible after edge N+2
        bus.in_valid = 1'b1;
        bus.op       = 1'b0;
        bus.a        = word_t'(Q7 - 1);
        bus.b        = '0;
        exp_q.push_back(word_t'(Q7 - 1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("lat_n1_out_valid", 64'(bus.out_valid), 64'(0));
        @(posedge clk);
        #1;
        check("lat_n2_out_valid", 64'(bus.out_valid), 64'(1));
        check("lat_n2_c", 64'(bus.c), 64'(Q7 - 1));
        drain();

        // Streaming from the vector table
        out_cycs.delete();
        foreach (vecs[i]) send(vecs[i]);
        drain();
        check("stream_count", 64'(out_cycs.size()), 64'(vecs.size()));
        for (int i = 1; i < out_cycs.size(); i++) begin
            check($sformatf("stream_consecutive_%0d", i), 64'(out_cycs[i] - out_cycs[i-1]),
                  64'(1));
        end

        // Backpressure: two accepted, third held off until out_ready returns
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op        = 1'b0;
        bus.a         = word_t'(Q7 - 1);
        bus.b         = word_t'(5);
        exp_q.push_back(word_t'(4));
        @(posedge clk);
        #1;
        check("bp_ready_after_1", 64'(bus.in_ready), 64'(1));
        bus.a = word_t'(Q7 - 2);
        bus.b = word_t'(Q7 - 3);
        exp_q.push_back(word_t'(Q7 - 5));
        @(posedge clk);
        #1;
        check("bp_ready_after_2", 64'(bus.in_ready), 64'(0));
        bus.a = word_t'(100);
        bus.b = word_t'(200);
        exp_q.push_back(word_t'(300));
        repeat (3) begin
            @(posedge clk);
            #1;
            check("bp_stall_c", 64'(bus.c), 64'(4));
            check("bp_stall_out_valid", 64'(bus.out_valid), 64'(1));
            check("bp_stall_in_ready", 64'(bus.in_ready), 64'(0));
        end
        out_cycs.delete();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain();
        repeat (4) @(posedge clk);
        #1;
        check("bp_result_count", 64'(out_cycs.size()), 64'(3));

        // Modulus switch in the same cycle as an accept
        bus.in_valid  = 1'b1;
        bus.op        = 1'b0;
        bus.a         = word_t'(Q7 - 1);
        bus.b         = word_t'(1);
        bus.mod_load  = 1'b1;
        bus.mod_index = IW'(3);
        exp_q.push_back(word_t'(0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.mod_load = 1'b0;
        check("cur_index_3", 64'(bus.cur_index), 64'(3));
        send(mk(0, Q3 - 1, 1, 0));
        send(mk(0, Q3 - 1, Q3 - 2, Q3 - 3));
        drain();

        // Reset with two operations in flight
        bus.out_ready = 1'b0;
        send(mk(0, 11, 22, 33));
        send(mk(0, 44, 55, 99));
        check("pre_rst_out_valid", 64'(bus.out_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst_c", 64'(bus.c), 64'(0));
        check("mid_rst_cur_index", 64'(bus.cur_index), 64'(0));
        exp_q.delete();
        out_cycs.delete();
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_stale_after_rst", 64'(out_cycs.size()), 64'(0));
        check("in_ready_after_mid_rst", 64'(bus.in_ready), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
